// File: rtl/mem_port_arbiter_if.sv
// Signal bundle between the memory port arbiter, its two requesters and the bus slave.
// Handshakes: a requester holds *_req high until its one-cycle *_done pulse and drops it on that cycle.
// On the bus, bus_req and its qualifiers stay stable until the slave returns bus_ack for one cycle.
interface mem_port_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_done;
    logic [31:0] if_rdata;
    logic        if_fault;

    logic        d_req;
    logic [3:0]  d_type;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_done;
    logic [31:0] d_rdata;
    logic        d_misaligned;
    logic        d_fault;

    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    modport master (
        input  if_req, if_addr, d_req, d_type, d_addr, d_wdata, bus_ack, bus_rdata,
        output if_done, if_rdata, if_fault, d_done, d_rdata, d_misaligned, d_fault,
        output bus_req, bus_we, bus_addr, bus_be, bus_wdata
    );

    modport slave (
        output if_req, if_addr, d_req, d_type, d_addr, d_wdata, bus_ack, bus_rdata,
        input  if_done, if_rdata, if_fault, d_done, d_rdata, d_misaligned, d_fault,
        input  bus_req, bus_we, bus_addr, bus_be, bus_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one 32-bit memory port between instruction fetch and load/store access.
// Define MEM_ARB_TIMEOUT_EN to abort bus cycles that see no bus_ack within TIMEOUT_CYCLES.
module mem_port_arbiter #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int FETCH_PRIORITY = 0
) (
    input  logic               clk,
    input  logic               rst,
    output logic [1:0]         dbg_state,
    mem_port_arbiter_if.master mp
);
    typedef enum logic [1:0] {IDLE = 2'd0, BUS = 2'd1, RESP = 2'd2} state_t;

    localparam logic [1:0] SZ_B = 2'b01;
    localparam logic [1:0] SZ_H = 2'b10;
    localparam logic [1:0] SZ_W = 2'b11;

    state_t      state_q, state_d;
    logic        sel_data_q, sel_data_d;
    logic [1:0]  off_q, off_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic        bus_req_q, bus_req_d;
    logic        bus_we_q, bus_we_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [3:0]  bus_be_q, bus_be_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic        if_done_q, if_done_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic        if_fault_q, if_fault_d;
    logic        d_done_q, d_done_d;
    logic [31:0] d_rdata_q, d_rdata_d;
    logic        d_misaligned_q, d_misaligned_d;
    logic        d_fault_q, d_fault_d;

    logic        d_is_load, d_uns, d_valid, d_misal;
    logic [1:0]  d_size;
    logic [3:0]  d_be;
    logic [31:0] d_wdata_rep;
    logic [31:0] ld_shift, ld_value;
    logic        pick_d, pick_f;
    logic        tmo_expire;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_q, tmo_d;

    always_comb begin
        tmo_d = '0;
        if (state_q == BUS && !mp.bus_ack) tmo_d = tmo_q + TW'(1);
    end

    assign tmo_expire = (state_q == BUS) && (tmo_q == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) tmo_q <= '0;
        else     tmo_q <= tmo_d;
    end
`else
    logic unused_tmo;
    assign tmo_expire = 1'b0;
    assign unused_tmo = (TIMEOUT_CYCLES != 0);
`endif

    // Type code: bit3 load, bits[2:1] size (01 byte, 10 half, 11 word), bit0 unsigned.
    always_comb begin
        d_is_load   = mp.d_type[3];
        d_size      = mp.d_type[2:1];
        d_uns       = mp.d_type[0];
        d_valid     = (d_size != 2'b00) && !(d_uns && (!d_is_load || d_size == SZ_W));
        d_misal     = d_valid && (((d_size == SZ_H) && mp.d_addr[0]) ||
                                  ((d_size == SZ_W) && (mp.d_addr[1:0] != 2'b00)));
        d_be        = 4'b1111;
        d_wdata_rep = mp.d_wdata;
        case (d_size)
            SZ_B: begin
                d_be        = 4'b0001 << mp.d_addr[1:0];
                d_wdata_rep = {4{mp.d_wdata[7:0]}};
            end
            SZ_H: begin
                d_be        = 4'b0011 << mp.d_addr[1:0];
                d_wdata_rep = {2{mp.d_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        ld_shift = mp.bus_rdata >> {off_q, 3'b000};
        case (size_q)
            SZ_B:    ld_value = uns_q ? {24'h0, ld_shift[7:0]}  : {{24{ld_shift[7]}}, ld_shift[7:0]};
            SZ_H:    ld_value = uns_q ? {16'h0, ld_shift[15:0]} : {{16{ld_shift[15]}}, ld_shift[15:0]};
            default: ld_value = mp.bus_rdata;
        endcase
    end

    assign pick_d = mp.d_req && (!mp.if_req || (FETCH_PRIORITY == 0));
    assign pick_f = mp.if_req && !pick_d;

    always_comb begin
        state_d        = state_q;
        sel_data_d     = sel_data_q;
        off_d          = off_q;
        size_d         = size_q;
        uns_d          = uns_q;
        bus_req_d      = bus_req_q;
        bus_we_d       = bus_we_q;
        bus_addr_d     = bus_addr_q;
        bus_be_d       = bus_be_q;
        bus_wdata_d    = bus_wdata_q;
        if_done_d      = 1'b0;
        if_rdata_d     = '0;
        if_fault_d     = 1'b0;
        d_done_d       = 1'b0;
        d_rdata_d      = '0;
        d_misaligned_d = 1'b0;
        d_fault_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (pick_d) begin
                    sel_data_d = 1'b1;
                    off_d      = mp.d_addr[1:0];
                    size_d     = d_size;
                    uns_d      = d_uns;
                    if (d_misal || !d_valid) begin
                        d_done_d       = 1'b1;
                        d_misaligned_d = d_misal;
                        state_d        = RESP;
                    end else begin
                        bus_req_d   = 1'b1;
                        bus_we_d    = !d_is_load;
                        bus_addr_d  = {mp.d_addr[31:2], 2'b00};
                        bus_be_d    = d_be;
                        bus_wdata_d = d_is_load ? 32'h0 : d_wdata_rep;
                        state_d     = BUS;
                    end
                end else if (pick_f) begin
                    sel_data_d = 1'b0;
                    off_d      = 2'b00;
                    size_d     = SZ_W;
                    uns_d      = 1'b0;
                    if (mp.if_addr[1:0] != 2'b00) begin
                        if_done_d  = 1'b1;
                        if_fault_d = 1'b1;
                        state_d    = RESP;
                    end else begin
                        bus_req_d   = 1'b1;
                        bus_we_d    = 1'b0;
                        bus_addr_d  = {mp.if_addr[31:2], 2'b00};
                        bus_be_d    = 4'b1111;
                        bus_wdata_d = 32'h0;
                        state_d     = BUS;
                    end
                end
            end
            BUS: begin
                // An ack in the expiry cycle takes precedence over the timeout.
                if (mp.bus_ack || tmo_expire) begin
                    bus_req_d   = 1'b0;
                    bus_we_d    = 1'b0;
                    bus_addr_d  = '0;
                    bus_be_d    = '0;
                    bus_wdata_d = '0;
                    state_d     = RESP;
                    if (sel_data_q) begin
                        d_done_d  = 1'b1;
                        d_fault_d = !mp.bus_ack;
                        d_rdata_d = (mp.bus_ack && !bus_we_q) ? ld_value : 32'h0;
                    end else begin
                        if_done_d  = 1'b1;
                        if_fault_d = !mp.bus_ack;
                        if_rdata_d = mp.bus_ack ? mp.bus_rdata : 32'h0;
                    end
                end
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            sel_data_q     <= 1'b0;
            off_q          <= '0;
            size_q         <= '0;
            uns_q          <= 1'b0;
            bus_req_q      <= 1'b0;
            bus_we_q       <= 1'b0;
            bus_addr_q     <= '0;
            bus_be_q       <= '0;
            bus_wdata_q    <= '0;
            if_done_q      <= 1'b0;
            if_rdata_q     <= '0;
            if_fault_q     <= 1'b0;
            d_done_q       <= 1'b0;
            d_rdata_q      <= '0;
            d_misaligned_q <= 1'b0;
            d_fault_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            sel_data_q     <= sel_data_d;
            off_q          <= off_d;
            size_q         <= size_d;
            uns_q          <= uns_d;
            bus_req_q      <= bus_req_d;
            bus_we_q       <= bus_we_d;
            bus_addr_q     <= bus_addr_d;
            bus_be_q       <= bus_be_d;
            bus_wdata_q    <= bus_wdata_d;
            if_done_q      <= if_done_d;
            if_rdata_q     <= if_rdata_d;
            if_fault_q     <= if_fault_d;
            d_done_q       <= d_done_d;
            d_rdata_q      <= d_rdata_d;
            d_misaligned_q <= d_misaligned_d;
            d_fault_q      <= d_fault_d;
        end
    end

    assign dbg_state       = state_q;
    assign mp.bus_req      = bus_req_q;
    assign mp.bus_we       = bus_we_q;
    assign mp.bus_addr     = bus_addr_q;
    assign mp.bus_be       = bus_be_q;
    assign mp.bus_wdata    = bus_wdata_q;
    assign mp.if_done      = if_done_q;
    assign mp.if_rdata     = if_rdata_q;
    assign mp.if_fault     = if_fault_q;
    assign mp.d_done       = d_done_q;
    assign mp.d_rdata      = d_rdata_q;
    assign mp.d_misaligned = d_misaligned_q;
    assign mp.d_fault      = d_fault_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: bus slave model, response/bus scoreboards, directed and random accesses.
module tb_mem_port_arbiter;
    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] dbg_state;

    mem_port_arbiter_if bif();

    mem_port_arbiter #(.TIMEOUT_CYCLES(8), .FETCH_PRIORITY(0)) dut (
        .clk       (clk),
        .rst       (rst),
        .dbg_state (dbg_state),
        .mp        (bif)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [34:0] exp_q[$];      // {is_data, fault, misaligned, rdata}
    logic [68:0] bus_exp_q[$];  // {we, addr, be, wdata}
    bit          slave_en = 1'b1;
    int          ack_wait = 0;
    int          wait_cnt = 0;
    logic [31:0] slave_rdata = '0;
    logic        prev_req = 1'b0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic check_outs_zero(input string tag);
        check({tag, "_resp"}, {bif.if_done, bif.if_rdata, bif.if_fault, bif.d_done, bif.d_rdata,
                               bif.d_misaligned, bif.d_fault, dbg_state}, '0);
        check({tag, "_bus"}, {bif.bus_req, bif.bus_we, bif.bus_addr, bif.bus_be, bif.bus_wdata}, '0);
    endtask

    // Reference behaviour worked out lane by lane.
    task automatic model(input bit is_data, input logic [3:0] t, input logic [31:0] a, w, rd,
                         output logic [34:0] resp, output bit ub, output logic [68:0] bexp);
        int n, off;
        bit ld, sx;
        logic [3:0]  be;
        logic [31:0] wd, v;
        ub = 1'b0; bexp = '0; off = int'(a[1:0]);
        n = 0; ld = 1'b0; sx = 1'b0;
        if (!is_data) begin
            if (off != 0) resp = {1'b0, 1'b1, 1'b0, 32'h0};
            else begin
                resp = {1'b0, 1'b0, 1'b0, rd};
                ub = 1'b1;
                bexp = {1'b0, a, 4'hf, 32'h0};
            end
        end else begin
            case (t)
                4'b1010: begin n = 1; ld = 1'b1; sx = 1'b1; end
                4'b1011: begin n = 1; ld = 1'b1; end
                4'b1100: begin n = 2; ld = 1'b1; sx = 1'b1; end
                4'b1101: begin n = 2; ld = 1'b1; end
                4'b1110: begin n = 4; ld = 1'b1; end
                4'b0010: n = 1;
                4'b0100: n = 2;
                4'b0110: n = 4;
                default: n = 0;
            endcase
            if (n == 0) resp = {1'b1, 1'b0, 1'b0, 32'h0};
            else if ((off % n) != 0) resp = {1'b1, 1'b0, 1'b1, 32'h0};
            else begin
                be = '0; wd = '0; v = '0;
                for (int i = 0; i < n; i++) begin
                    be[off + i] = 1'b1;
                    v[8*i +: 8] = rd[8*(off + i) +: 8];
                end
                for (int k = 0; k < 4; k++) wd[8*k +: 8] = w[8*(k % n) +: 8];
                if (sx && v[8*n - 1]) for (int i = 8*n; i < 32; i++) v[i] = 1'b1;
                ub = 1'b1;
                bexp = {!ld, a[31:2], 2'b00, be, ld ? 32'h0 : wd};
                resp = {1'b1, 1'b0, 1'b0, ld ? v : 32'h0};
            end
        end
    endtask

    // Slave: acks after ack_wait cycles; toggles ack randomly while idle to test it is ignored.
    always @(negedge clk) begin
        if (bif.bus_req && slave_en) begin
            if (wait_cnt >= ack_wait) begin
                bif.bus_ack = 1'b1; bif.bus_rdata = slave_rdata; wait_cnt = 0;
            end else begin
                bif.bus_ack = 1'b0; bif.bus_rdata = $urandom; wait_cnt++;
            end
        end else begin
            bif.bus_ack   = bif.bus_req ? 1'b0 : 1'($urandom_range(0, 1));
            bif.bus_rdata = $urandom;
            wait_cnt      = 0;
        end
    end

    always @(negedge clk) begin : bus_mon
        logic [68:0] e;
        if (bif.bus_req && !prev_req) begin
            if (bus_exp_q.size() == 0) check("bus_unexpected", bus_exp_q.size(), 1);
            else begin
                e = bus_exp_q.pop_front();
                check("bus_cycle", {bif.bus_we, bif.bus_addr, bif.bus_be,
                                    bif.bus_we ? bif.bus_wdata : 32'h0}, e);
            end
        end
        prev_req = bif.bus_req;
    end

    always @(negedge clk) begin : resp_mon
        logic [34:0] e;
        if (bif.if_done || bif.d_done) begin
            check("one_done", bif.if_done & bif.d_done, 1'b0);
            if (exp_q.size() == 0) check("resp_unexpected", exp_q.size(), 1);
            else begin
                e = exp_q.pop_front();
                check("resp", bif.d_done ? {1'b1, bif.d_fault, bif.d_misaligned, bif.d_rdata}
                                         : {1'b0, bif.if_fault, 1'b0, bif.if_rdata}, e);
            end
        end
    end

    task automatic access(input bit is_data, input logic [3:0] t, input logic [31:0] a, w, rd,
                          input int waits);
        logic [34:0] r;
        logic [68:0] b;
        bit ub, seen;
        int cyc;
        model(is_data, t, a, w, rd, r, ub, b);
        @(negedge clk);
        exp_q.push_back(r);
        if (ub) bus_exp_q.push_back(b);
        slave_rdata = rd;
        ack_wait    = waits;
        if (is_data) begin
            bif.d_req = 1'b1; bif.d_type = t; bif.d_addr = a; bif.d_wdata = w;
        end else begin
            bif.if_req = 1'b1; bif.if_addr = a;
        end
        cyc = 0; seen = 1'b0;
        while (!seen && cyc < 100) begin
            @(negedge clk);
            cyc++;
            seen = is_data ? bif.d_done : bif.if_done;
        end
        if (is_data) check("d_latency", cyc, ub ? 2 + waits : 1);
        else         check("if_latency", cyc, ub ? 2 + waits : 1);
        bif.d_req  = 1'b0;
        bif.if_req = 1'b0;
    endtask

    task automatic both_access(input logic [31:0] ia, input logic [3:0] t, input logic [31:0] da, w, rd);
        logic [34:0] rd_exp, rf_exp;
        logic [68:0] bd_exp, bf_exp;
        bit ubd, ubf;
        int cyc, d_cyc, f_cyc;
        model(1'b1, t, da, w, rd, rd_exp, ubd, bd_exp);
        model(1'b0, 4'h0, ia, 32'h0, rd, rf_exp, ubf, bf_exp);
        @(negedge clk);
        exp_q.push_back(rd_exp);
        exp_q.push_back(rf_exp);
        if (ubd) bus_exp_q.push_back(bd_exp);
        if (ubf) bus_exp_q.push_back(bf_exp);
        slave_rdata = rd; ack_wait = 0;
        bif.d_req = 1'b1; bif.d_type = t; bif.d_addr = da; bif.d_wdata = w;
        bif.if_req = 1'b1; bif.if_addr = ia;
        cyc = 0; d_cyc = -1; f_cyc = -1;
        while ((d_cyc < 0 || f_cyc < 0) && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (bif.d_done)  begin bif.d_req = 1'b0;  d_cyc = cyc; end
            if (bif.if_done) begin bif.if_req = 1'b0; f_cyc = cyc; end
        end
        check("both_d_latency", d_cyc, 2);
        check("both_if_latency", f_cyc, 5);
        bif.d_req = 1'b0; bif.if_req = 1'b0;
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [3:0] codes [10];
        int cyc, busc;
        bit seen;
        codes = '{4'b1010, 4'b1011, 4'b1100, 4'b1101, 4'b1110,
                  4'b0010, 4'b0100, 4'b0110, 4'b0000, 4'b1111};

        rst = 1'b1;
        bif.if_req = 1'b0; bif.if_addr = '0;
        bif.d_req = 1'b0; bif.d_type = '0; bif.d_addr = '0; bif.d_wdata = '0;
        bif.bus_ack = 1'b0; bif.bus_rdata = '0;
        repeat (3) @(negedge clk);
        check_outs_zero("reset");
        rst = 1'b0;

        access(1'b0, 4'h0,    32'h0000_0010, 32'h0,         32'h0000_0013, 2);
        access(1'b1, 4'b1010, 32'h0000_0103, 32'h0,         32'h80AA_BBCC, 0);
        access(1'b1, 4'b1011, 32'h0000_0103, 32'h0,         32'h80AA_BBCC, 1);
        access(1'b1, 4'b0100, 32'h0000_0202, 32'h1234_5678, 32'h0,         0);
        access(1'b1, 4'b1110, 32'h0000_0301, 32'h0,         32'h0,         0);
        access(1'b1, 4'b1100, 32'h0000_0002, 32'h0,         32'h8001_7FFF, 0);
        access(1'b1, 4'b1101, 32'h0000_0002, 32'h0,         32'h8001_7FFF, 0);
        access(1'b1, 4'b0010, 32'h0000_0011, 32'hDEAD_BEA5, 32'h0,         3);
        access(1'b1, 4'b0110, 32'h0000_0020, 32'hCAFE_F00D, 32'h0,         0);
        access(1'b1, 4'b1100, 32'h0000_0003, 32'h0,         32'h0,         0);
        access(1'b1, 4'b0000, 32'h0000_0040, 32'h0,         32'h0,         0);
        access(1'b1, 4'b1111, 32'h0000_0040, 32'h0,         32'h0,         0);
        access(1'b0, 4'h0,    32'h0000_0102, 32'h0,         32'h0,         0);
        both_access(32'h0000_0080, 4'b1110, 32'h0000_0400, 32'h0, 32'h1357_9BDF);

        for (int i = 0; i < 24; i++) begin
            logic [31:0] a;
            a = $urandom;
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            access(($urandom_range(0, 3) != 0), codes[$urandom_range(0, 9)], a, $urandom, $urandom,
                   $urandom_range(0, 3));
        end

`ifdef MEM_ARB_TIMEOUT_EN
        slave_en = 1'b0;
        @(negedge clk);
        exp_q.push_back({1'b1, 1'b1, 1'b0, 32'h0});
        bus_exp_q.push_back({1'b0, 32'h0000_0500, 4'hf, 32'h0});
        bif.d_req = 1'b1; bif.d_type = 4'b1110; bif.d_addr = 32'h0000_0500;
        cyc = 0; busc = 0; seen = 1'b0;
        while (!seen && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (bif.bus_req) busc++;
            seen = bif.d_done;
        end
        check("tmo_latency", cyc, 9);
        check("tmo_bus_cycles", busc, 8);
        bif.d_req = 1'b0;
        slave_en = 1'b1;
`endif

        slave_en = 1'b0;
        @(negedge clk);
        bus_exp_q.push_back({1'b0, 32'h0000_0600, 4'hf, 32'h0});
        bif.d_req = 1'b1; bif.d_type = 4'b1110; bif.d_addr = 32'h0000_0600;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        bif.d_req = 1'b0;
        @(negedge clk);
        check_outs_zero("mid_rst");
        rst = 1'b0;
        slave_en = 1'b1;
        repeat (2) @(negedge clk);
        check_outs_zero("post_rst");
        access(1'b1, 4'b1010, 32'h0000_0701, 32'h0, 32'h0000_7F00, 1);

        repeat (5) @(negedge clk);
        check("resp_queue_drained", exp_q.size(), 0);
        check("bus_queue_drained", bus_exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
